// File: rtl/bht_btb_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with per-entry saturating counters.
// Fetch gets a zero-latency taken/target guess. The resolving stage feeds back the outcome,
// which trains the tables, raises mispredict/redirect and bumps saturating statistics.
module bht_btb_predictor #(
    parameter int ENTRIES   = 16,
    parameter int TAG_BITS  = 8,
    parameter int CNT_BITS  = 2,
    parameter int MODE      = 1,
    parameter int GHR_BITS  = 4,
    parameter int STAT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic [31:0]          lk_pc,
    output logic                 lk_taken,
    output logic [31:0]          lk_target,
    output logic [GHR_BITS-1:0]  lk_ghr,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_jump,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target,
    input  logic                 upd_pred_taken,
    input  logic [31:0]          upd_pred_target,
    input  logic [GHR_BITS-1:0]  upd_ghr,
    output logic                 mispredict,
    output logic [31:0]          redirect_pc,
    output logic [STAT_BITS-1:0] stat_branches,
    output logic [STAT_BITS-1:0] stat_mispred
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam logic [CNT_BITS-1:0]  CNT_WEAK_NT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0]  CNT_WEAK_T  = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0]  CNT_MAX     = '1;
    localparam logic [STAT_BITS-1:0] STAT_MAX    = '1;

    // Table storage is kept in flops so the lookup can read it in the same cycle.
    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic                jump_q   [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

    logic [GHR_BITS-1:0]  ghr_q;
    logic [STAT_BITS-1:0] stat_branches_q;
    logic [STAT_BITS-1:0] stat_mispred_q;

    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic                lk_hit;
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic                upd_hit;
    logic                upd_accept;
    logic [CNT_BITS-1:0] cnt_cur;
    logic                wr_en;
    logic [CNT_BITS-1:0] ent_cnt_d;
    logic [31:0]         ent_target_d;
    logic                ent_jump_d;

    // Bimodal uses the PC word index directly; gshare folds the global history into the low bits.
    function automatic logic [IDX_BITS-1:0] calc_idx(input logic [31:0] pc,
                                                     input logic [GHR_BITS-1:0] ghr);
        logic [IDX_BITS-1:0] base;
        base = pc[IDX_BITS+1:2];
        if (MODE == 2) begin
            return base ^ IDX_BITS'(ghr);
        end
        return base;
    endfunction

    function automatic logic [TAG_BITS-1:0] calc_tag(input logic [31:0] pc);
        return pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    endfunction

    // Lookup path: pure combinational read of the current table contents (no update bypass).
    assign lk_idx    = calc_idx(lk_pc, ghr_q);
    assign lk_tag    = calc_tag(lk_pc);
    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken  = (MODE != 0) && lk_hit && (jump_q[lk_idx] || cnt_q[lk_idx][CNT_BITS-1]);
    assign lk_target = lk_taken ? target_q[lk_idx] : (lk_pc + 32'd4);
    assign lk_ghr    = ghr_q;

    // Resolution path: mispredict is reported even while stalled so the pipeline can react.
    assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                       (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : (upd_pc + 32'd4);
    assign upd_accept  = upd_valid && !stall;

    assign upd_idx = calc_idx(upd_pc, upd_ghr);
    assign upd_tag = calc_tag(upd_pc);

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;

    // Next contents of the entry addressed by the resolving instruction.
    always_comb begin
        upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        cnt_cur      = cnt_q[upd_idx];
        wr_en        = 1'b0;
        ent_cnt_d    = cnt_cur;
        ent_target_d = target_q[upd_idx];
        ent_jump_d   = jump_q[upd_idx];
        if (upd_accept && (MODE != 0)) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                // Unconditional jumps are predicted by the jump bit, so they leave the counter alone.
                if (!upd_jump) begin
                    if (upd_taken) begin
                        if (cnt_cur != CNT_MAX) begin
                            ent_cnt_d = cnt_cur + CNT_BITS'(1);
                        end
                    end else if (cnt_cur != '0) begin
                        ent_cnt_d = cnt_cur - CNT_BITS'(1);
                    end
                end
                if (upd_taken) begin
                    ent_target_d = upd_target;
                    ent_jump_d   = upd_jump;
                end
            end else if (upd_taken) begin
                // Only taken branches earn an entry; they start out weakly taken.
                wr_en        = 1'b1;
                ent_cnt_d    = CNT_WEAK_T;
                ent_target_d = upd_target;
                ent_jump_d   = upd_jump;
            end
        end
    end

    // Table write: reset clears every entry, otherwise one entry is (re)written per accepted update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                jump_q[i]   <= 1'b0;
                cnt_q[i]    <= CNT_WEAK_NT;
            end
        end else if (wr_en) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= ent_target_d;
            jump_q[upd_idx]   <= ent_jump_d;
            cnt_q[upd_idx]    <= ent_cnt_d;
        end
    end

    // Global history and saturating statistics advance once per accepted update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr_q           <= '0;
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else if (upd_accept) begin
            if ((MODE == 2) && !upd_jump) begin
                ghr_q <= GHR_BITS'({ghr_q, upd_taken});
            end
            if (stat_branches_q != STAT_MAX) begin
                stat_branches_q <= stat_branches_q + STAT_BITS'(1);
            end
            if (mispredict && (stat_mispred_q != STAT_MAX)) begin
                stat_mispred_q <= stat_mispred_q + STAT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_bht_btb_predictor.sv
// Directed bench for bht_btb_predictor: a bimodal instance is checked for lookups, training,
// aliasing, stall and reset behaviour; a gshare instance with 3-bit statistics shares the same
// update stream to check history shifting and statistic saturation.
module tb_bht_btb_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] lk_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic [3:0]  upd_ghr;

    logic        lk_taken;
    logic [31:0] lk_target;
    logic [3:0]  lk_ghr;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    logic        gs_lk_taken;
    logic [31:0] gs_lk_target;
    logic [3:0]  gs_lk_ghr;
    logic        gs_mispredict;
    logic [31:0] gs_redirect_pc;
    logic [2:0]  gs_stat_branches;
    logic [2:0]  gs_stat_mispred;

    int          checks_cnt = 0;
    int          errors_cnt = 0;
    logic [31:0] exp_b;
    logic [31:0] exp_m;
    logic [3:0]  exp_ghr;

    always #5 clk = ~clk;

    bht_btb_predictor #(
        .ENTRIES(16), .TAG_BITS(8), .CNT_BITS(2), .MODE(1), .GHR_BITS(4), .STAT_BITS(32)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .lk_pc(lk_pc), .lk_taken(lk_taken), .lk_target(lk_target), .lk_ghr(lk_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_jump(upd_jump), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    bht_btb_predictor #(
        .ENTRIES(16), .TAG_BITS(8), .CNT_BITS(2), .MODE(2), .GHR_BITS(4), .STAT_BITS(3)
    ) u_gs (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .lk_pc(lk_pc), .lk_taken(gs_lk_taken), .lk_target(gs_lk_target), .lk_ghr(gs_lk_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_jump(upd_jump), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
        .mispredict(gs_mispredict), .redirect_pc(gs_redirect_pc),
        .stat_branches(gs_stat_branches), .stat_mispred(gs_stat_mispred)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_stats(input string tag);
        check_val({tag, "_branches"}, stat_branches, exp_b);
        check_val({tag, "_mispred"}, stat_mispred, exp_m);
        check_val({tag, "_gs_branches"}, 32'(gs_stat_branches), (exp_b > 32'd7) ? 32'd7 : exp_b);
        check_val({tag, "_gs_mispred"}, 32'(gs_stat_mispred), (exp_m > 32'd7) ? 32'd7 : exp_m);
        check_val({tag, "_gs_ghr"}, 32'(gs_lk_ghr), 32'(exp_ghr));
    endtask

    task automatic check_lk(input string tag, input logic [31:0] pc,
                            input logic exp_tk, input logic [31:0] exp_tgt);
        @(posedge clk);
        #1;
        lk_pc = pc;
        #1;
        check_val({tag, "_taken"}, 32'(lk_taken), 32'(exp_tk));
        check_val({tag, "_target"}, lk_target, exp_tgt);
        $display("lookup pc=%08h taken=%0d target=%08h", pc, lk_taken, lk_target);
    endtask

    task automatic do_upd(input string tag, input logic [31:0] pc, input logic jmp,
                          input logic tk, input logic [31:0] tgt, input logic ptk,
                          input logic [31:0] ptgt, input logic exp_mis);
        @(posedge clk);
        #1;
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_jump        = jmp;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        #1;
        check_val({tag, "_mispredict"}, 32'(mispredict), 32'(exp_mis));
        check_val({tag, "_redirect"}, redirect_pc, tk ? tgt : (pc + 32'd4));
        $display("update pc=%08h jump=%0d taken=%0d target=%08h mispredict=%0d redirect=%08h",
                 pc, jmp, tk, tgt, mispredict, redirect_pc);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        exp_b++;
        if (exp_mis) exp_m++;
        if (!jmp) exp_ghr = {exp_ghr[2:0], tk};
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; lk_pc = 32'h40;
        upd_valid = 1'b0; upd_pc = '0; upd_jump = 1'b0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0; upd_ghr = '0;
        exp_b = '0; exp_m = '0; exp_ghr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        // Reset state
        check_val("rst_lk_taken", 32'(lk_taken), 32'd0);
        check_val("rst_lk_target", lk_target, 32'h44);
        check_val("rst_mispredict", 32'(mispredict), 32'd0);
        check_stats("rst");

        // First taken branch: mispredicts, allocates, lookup in the same cycle sees old contents
        @(posedge clk);
        #1;
        upd_valid = 1'b1; upd_pc = 32'h40; upd_jump = 1'b0; upd_taken = 1'b1;
        upd_target = 32'h80; upd_pred_taken = 1'b0; upd_pred_target = 32'h44;
        #1;
        check_val("alloc_mispredict", 32'(mispredict), 32'd1);
        check_val("alloc_redirect", redirect_pc, 32'h80);
        check_val("alloc_no_bypass", 32'(lk_taken), 32'd0);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        exp_b++; exp_m++; exp_ghr = {exp_ghr[2:0], 1'b1};
        #1;
        $display("update pc=00000040 taken=1 target=00000080 allocated");
        check_val("alloc_lk_taken", 32'(lk_taken), 32'd1);
        check_val("alloc_lk_target", lk_target, 32'h80);
        check_stats("alloc");

        // Counter training: 2 -> 1 -> 0 -> 0 (floor), then 1, 2, 3, 3 (ceiling), then 2
        do_upd("nt1", 32'h40, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1);
        check_lk("nt1", 32'h40, 1'b0, 32'h44);
        do_upd("nt2", 32'h40, 1'b0, 1'b0, 32'h80, 1'b0, 32'h44, 1'b0);
        do_upd("nt3", 32'h40, 1'b0, 1'b0, 32'h80, 1'b0, 32'h44, 1'b0);
        check_lk("nt3", 32'h40, 1'b0, 32'h44);
        do_upd("t1", 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44, 1'b1);
        check_lk("t1", 32'h40, 1'b0, 32'h44);
        do_upd("t2", 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44, 1'b1);
        check_lk("t2", 32'h40, 1'b1, 32'h80);
        do_upd("t3", 32'h40, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
        do_upd("t4", 32'h40, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
        do_upd("nt4", 32'h40, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1);
        check_lk("nt4", 32'h40, 1'b1, 32'h80);
        check_stats("train");

        // jal at 0x100 (same index as 0x40) predicted taken on every lookup
        do_upd("jal", 32'h100, 1'b1, 1'b1, 32'h20, 1'b0, 32'h104, 1'b1);
        for (int i = 0; i < 4; i++) check_lk("jal_lk", 32'h100, 1'b1, 32'h20);
        check_lk("jal_evict", 32'h40, 1'b0, 32'h44);
        check_stats("jal");

        // Aliasing: 0x40 reallocated, then 0x80 overwrites the same entry (target-only mispredict)
        do_upd("re40", 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44, 1'b1);
        check_lk("re40", 32'h40, 1'b1, 32'h80);
        do_upd("alias", 32'h80, 1'b0, 1'b1, 32'h200, 1'b1, 32'h90, 1'b1);
        check_lk("alias_old", 32'h40, 1'b0, 32'h44);
        check_lk("alias_new", 32'h80, 1'b1, 32'h200);
        check_stats("alias");

        // Stall held with a mispredicting update: flagged every cycle, applied only once
        lk_pc = 32'h204;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            stall = 1'b1; upd_valid = 1'b1; upd_pc = 32'h204; upd_jump = 1'b0; upd_taken = 1'b1;
            upd_target = 32'h300; upd_pred_taken = 1'b0; upd_pred_target = 32'h208;
            #1;
            check_val("stall_mispredict", 32'(mispredict), 32'd1);
            check_val("stall_lk_taken", 32'(lk_taken), 32'd0);
            check_stats("stall");
            $display("stalled update pc=00000204 mispredict=%0d", mispredict);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        #1;
        check_val("unstall_mispredict", 32'(mispredict), 32'd1);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        exp_b++; exp_m++; exp_ghr = {exp_ghr[2:0], 1'b1};
        #1;
        $display("update pc=00000204 applied after stall");
        check_stats("unstall");
        check_lk("unstall", 32'h204, 1'b1, 32'h300);
        check_stats("unstall_hold");

        // Reset with a concurrent update: reset wins, nothing written
        @(posedge clk);
        #1;
        rst_n = 1'b0; upd_valid = 1'b1; upd_pc = 32'h40; upd_jump = 1'b0; upd_taken = 1'b1;
        upd_target = 32'h80; upd_pred_taken = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; upd_valid = 1'b0;
        exp_b = '0; exp_m = '0; exp_ghr = '0;
        #1;
        $display("reset with concurrent update");
        check_stats("midrst");
        check_lk("midrst_204", 32'h204, 1'b0, 32'h208);
        check_lk("midrst_40", 32'h40, 1'b0, 32'h44);

        // PC wrap-around; mispredict gated by upd_valid
        @(posedge clk);
        #1;
        lk_pc = 32'hFFFF_FFFC; upd_pc = 32'hFFFF_FFFC; upd_taken = 1'b0; upd_pred_taken = 1'b1;
        upd_valid = 1'b0;
        #1;
        check_val("wrap_lk_target", lk_target, 32'h0);
        check_val("wrap_redirect", redirect_pc, 32'h0);
        check_val("novalid_mispredict", 32'(mispredict), 32'd0);
        $display("wrap lookup target=%08h redirect=%08h", lk_target, redirect_pc);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
